// File: rtl/vscale_hasti_sram_slave_pkg.sv
// Shared HASTI bus widths, encodings and the SRAM responder state type.
// Imported by the responder, its byte-enable decoder and the benches.
package vscale_hasti_sram_slave_pkg;

  localparam int HASTI_ADDR_WIDTH  = 32;
  localparam int HASTI_BUS_WIDTH   = 32;
  localparam int HASTI_SIZE_WIDTH  = 3;
  localparam int HASTI_BURST_WIDTH = 3;
  localparam int HASTI_PROT_WIDTH  = 4;
  localparam int HASTI_TRANS_WIDTH = 2;
  localparam int HASTI_RESP_WIDTH  = 1;
  localparam int HASTI_BUS_NBYTES  = HASTI_BUS_WIDTH / 8;

  localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_IDLE   = 2'd0;
  localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_BUSY   = 2'd1;
  localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_NONSEQ = 2'd2;
  localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_SEQ    = 2'd3;

  localparam logic [HASTI_RESP_WIDTH-1:0] HASTI_RESP_OKAY  = 1'b0;
  localparam logic [HASTI_RESP_WIDTH-1:0] HASTI_RESP_ERROR = 1'b1;

  localparam logic [HASTI_SIZE_WIDTH-1:0] HASTI_SIZE_BYTE = 3'd0;
  localparam logic [HASTI_SIZE_WIDTH-1:0] HASTI_SIZE_HALF = 3'd1;
  localparam logic [HASTI_SIZE_WIDTH-1:0] HASTI_SIZE_WORD = 3'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } sram_state_e;

  // True when a transfer of the given size starts on a naturally aligned byte.
  function automatic logic size_aligned(input logic [HASTI_SIZE_WIDTH-1:0] size,
                                        input logic [1:0]                  addr_lo);
    case (size)
      HASTI_SIZE_BYTE: return 1'b1;
      HASTI_SIZE_HALF: return ~addr_lo[0];
      HASTI_SIZE_WORD: return (addr_lo == 2'b00);
      default:         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/vscale_hasti_sram_slave_wmask.sv
// Size + byte offset to 4-lane byte-enable decode; purely combinational.
// Unsupported sizes produce no enables.
module vscale_hasti_wmask
  import vscale_hasti_sram_slave_pkg::*;
(
  input  logic [HASTI_SIZE_WIDTH-1:0] hsize,
  input  logic [1:0]                  addr_lo,
  output logic [HASTI_BUS_NBYTES-1:0] wmask
);

  always_comb begin
    wmask = '0;
    case (hsize)
      HASTI_SIZE_BYTE: wmask = 4'b0001 << addr_lo;
      HASTI_SIZE_HALF: wmask = addr_lo[1] ? 4'b1100 : 4'b0011;
      HASTI_SIZE_WORD: wmask = 4'b1111;
      default:         wmask = '0;
    endcase
  end

endmodule

// File: rtl/vscale_hasti_sram_slave.sv
// HASTI responder over a word-organised SRAM with byte-lane writes,
// fixed wait states per legal data phase and the two-cycle ERROR response.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | no data phase pending; address phase sampled
// ST_DATA | legal data phase; cnt_q stall cycles left, completes at 0
// ST_ERR1 | first ERROR cycle, hready low
// ST_ERR2 | second ERROR cycle, hready high; address phase sampled
module vscale_hasti_sram_slave
  import vscale_hasti_sram_slave_pkg::*;
#(
  parameter int          MEM_WORDS   = 1024,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] ADDR_BASE   = 32'h0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [HASTI_ADDR_WIDTH-1:0]    haddr,
  input  logic                           hwrite,
  input  logic [HASTI_SIZE_WIDTH-1:0]    hsize,
  input  logic [HASTI_BURST_WIDTH-1:0]   hburst,
  input  logic                           hmastlock,
  input  logic [HASTI_PROT_WIDTH-1:0]    hprot,
  input  logic [HASTI_TRANS_WIDTH-1:0]   htrans,
  input  logic [HASTI_BUS_WIDTH-1:0]     hwdata,
  output logic [HASTI_BUS_WIDTH-1:0]     hrdata,
  output logic                           hready,
  output logic [HASTI_RESP_WIDTH-1:0]    hresp,
  output logic [MEM_WORDS*HASTI_BUS_WIDTH-1:0] port_mem
);

  localparam int         IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  sram_state_e                 state_q, state_d;
  logic [3:0]                  cnt_q, cnt_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [1:0]                  lo_q, lo_d;
  logic                        write_q, write_d;
  logic [HASTI_SIZE_WIDTH-1:0] size_q, size_d;

  logic [HASTI_BUS_WIDTH-1:0]  mem_q [MEM_WORDS];

  logic [HASTI_ADDR_WIDTH-1:0] offset;
  logic                        in_range;
  logic                        active;
  logic                        legal;
  logic                        wr_en;
  logic [HASTI_BUS_NBYTES-1:0] be;

  // Range check is done on the base-relative word index so a wrapped
  // subtraction (haddr below ADDR_BASE) is rejected separately.
  assign offset   = haddr - ADDR_BASE;
  assign in_range = (haddr >= ADDR_BASE) && (offset[31:2] < 30'(MEM_WORDS));
  assign active   = (htrans == HASTI_TRANS_NONSEQ) || (htrans == HASTI_TRANS_SEQ);
  assign legal    = active && in_range && size_aligned(hsize, haddr[1:0]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      lo_q    <= '0;
      write_q <= 1'b0;
      size_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      lo_q    <= lo_d;
      write_q <= write_d;
      size_q  <= size_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    lo_d    = lo_q;
    write_d = write_q;
    size_d  = size_q;
    if (state_q == ST_ERR1) begin
      state_d = ST_ERR2;
    end else if (state_q == ST_DATA && cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end else if (legal) begin
      state_d = ST_DATA;
      cnt_d   = WAIT_INIT;
      idx_d   = offset[IDX_W+1:2];
      lo_d    = haddr[1:0];
      write_d = hwrite;
      size_d  = hsize;
    end else if (active) begin
      state_d = ST_ERR1;
    end else begin
      state_d = ST_IDLE;
    end
  end

  always_comb begin
    hready = 1'b1;
    hresp  = HASTI_RESP_OKAY;
    hrdata = '0;
    wr_en  = 1'b0;
    case (state_q)
      ST_DATA: begin
        if (cnt_q != 4'd0) begin
          hready = 1'b0;
        end else if (write_q) begin
          wr_en = 1'b1;
        end else begin
          hrdata = mem_q[idx_q];
        end
      end
      ST_ERR1: begin
        hready = 1'b0;
        hresp  = HASTI_RESP_ERROR;
      end
      ST_ERR2: hresp = HASTI_RESP_ERROR;
      default: ;
    endcase
  end

  vscale_hasti_wmask u_wmask (
    .hsize   (size_q),
    .addr_lo (lo_q),
    .wmask   (be)
  );

  // Array is deliberately left out of reset; writes are gated by state only.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < HASTI_BUS_NBYTES; b++) begin
        if (be[b]) mem_q[idx_q][8*b +: 8] <= hwdata[8*b +: 8];
      end
    end
  end

  for (genvar k = 0; k < MEM_WORDS; k++) begin : g_port_mem
    assign port_mem[HASTI_BUS_WIDTH*k +: HASTI_BUS_WIDTH] = mem_q[k];
  end

  logic unused_inputs;
  assign unused_inputs = ^{hburst, hmastlock, hprot, offset[1:0]};

endmodule

// File: doc/vscale_hasti_sram_slave.md
Name: vscale_hasti_sram_slave

Overview:
Single-port HASTI (AHB-lite) responder backed by a word-organised SRAM. It terminates one master port, either a core dmem/imem port directly or the arbiter output. It supports byte, half and word transfers with byte-lane writes, a configurable wait-state count, and the two-cycle ERROR response for illegal accesses. It exposes the whole array flattened on port_mem so that formal and simulation checks can observe it.

Parameters:
MEM_WORDS, 1024, number of 32-bit words; valid word index is 0..MEM_WORDS-1
WAIT_STATES, 0, number of hready-low cycles inserted in every legal data phase (0..15)
ADDR_BASE, 32'h0, byte address mapped to word 0

Ports:
clk  input  1  clock
reset  input  1  asynchronous active-high reset
haddr  input  HASTI_ADDR_WIDTH  address-phase byte address
hwrite  input  1  1 = write
hsize  input  HASTI_SIZE_WIDTH  0 byte, 1 half, 2 word
hburst  input  HASTI_BURST_WIDTH  ignored
hmastlock  input  1  ignored
hprot  input  HASTI_PROT_WIDTH  ignored
htrans  input  HASTI_TRANS_WIDTH  IDLE/BUSY/NONSEQ/SEQ
hwdata  input  HASTI_BUS_WIDTH  write data, valid in data phase
hrdata  output  HASTI_BUS_WIDTH  read data (full word, lanes unshifted)
hready  output  1  transfer-complete / slave ready
hresp  output  HASTI_RESP_WIDTH  0 OKAY, 1 ERROR
port_mem  output  MEM_WORDS*HASTI_BUS_WIDTH  flattened array; word k at bits [32k+31:32k]

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: state IDLE, hready=1, hresp=OKAY, hrdata=0, wait counter 0, captured address/control 0. SRAM contents are not reset.
- States: IDLE (no data phase pending), DATA (legal data phase, counter cnt), ERR1, ERR2.
- Sample point: an address phase is sampled only on cycles where hready=1. Those cycles are IDLE, DATA with cnt==0, and ERR2.
- Legal access, defined at the sample point:
  - htrans is NONSEQ or SEQ (SEQ is treated as NONSEQ using its own haddr);
  - word index (haddr-ADDR_BASE)>>2 is below MEM_WORDS and haddr is at or above ADDR_BASE;
  - hsize<=2;
  - size-aligned: half needs haddr[0]=0, word needs haddr[1:0]=0.
- Transitions at the sample point:
  - legal access -> capture haddr, hwrite, hsize; go to DATA with cnt=WAIT_STATES;
  - illegal NONSEQ/SEQ -> ERR1, nothing captured;
  - IDLE or BUSY htrans -> IDLE.
- DATA with cnt>0: hready=0, cnt decrements, the master holds its address. No address is sampled.
- DATA with cnt==0: hready=1, hresp=OKAY.
  - Read: hrdata = mem[captured word] combinationally from the registered index.
  - Write: hwdata lanes are written at this clock edge.
  - Byte enables: size 0 -> lane addr[1:0]; size 1 -> lanes {addr[1],0} and {addr[1],1}; size 2 -> all four.
- ERR1: hready=0, hresp=ERROR, no memory effect, then ERR2. ERR2: hready=1, hresp=ERROR.
- Error timing: errors never incur wait states.
- hrdata outside a read data-phase completion cycle is 0.
- Pipelined write-then-read to the same word: the read data phase follows the write completion edge, so it returns the new data. No bypass is needed.
- Reset mid-transaction: a pending write is discarded and outputs return to reset values immediately.
- port_mem reflects the array continuously. A write appears on port_mem the cycle after its completion edge.

Decomposition:
- Shared header (vscale_hasti_constants.vh) carries the existing widths plus named constants:
  - HASTI_TRANS_IDLE/BUSY/NONSEQ/SEQ;
  - HASTI_RESP_OKAY/ERROR;
  - HASTI_SIZE_BYTE/HALF/WORD.
- Local parameters for state encodings.
- Natural sub-module: vscale_hasti_wmask, a combinational size+offset -> 4-bit byte-enable decoder reused by the arbiter and tests.

Test Plan:
- WAIT_STATES=0: NONSEQ word write 0xDEADBEEF @0x10, then NONSEQ word read @0x10 -> hready stays 1; read completion hrdata=0xDEADBEEF; port_mem word 4 = 0xDEADBEEF.
- Word 0x11223344 @0x10, then byte write @0x13 with hwdata=0xAB000000 -> word becomes 0xAB223344. Half write @0x10 with hwdata=0x0000BEEF -> 0xAB22BEEF.
- WAIT_STATES=2, read @0x10 -> hready low for exactly 2 cycles, then high with correct hrdata. A second NONSEQ presented during the wait is sampled only on the hready-high cycle.
- MEM_WORDS=1024, word write @0x1000 -> ERR1 (hready=0, hresp=1), then ERR2 (hready=1, hresp=1); port_mem unchanged. Half @0x1 and word @0x2 -> same two-cycle ERROR.
- Back-to-back NONSEQ write @0x20 (0xCAFEF00D) and read @0x20 -> read returns 0xCAFEF00D; an IDLE/BUSY address phase -> OKAY, no data-phase effect.
- WAIT_STATES=3, write @0x30 with 0x12345678, reset asserted during the second wait cycle -> hready=1 and hresp=0 asynchronously; word 0x30 unchanged.
